// File: rtl/ps2_pkg.sv
// Shared types, scan codes and key decode helpers for the PS/2 key tracker.
// The arrow-key mapping is used only when PS2_ARROW_KEYS_EN is defined.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } state_t;

   localparam logic [7:0] PS2_BRK  = 8'hF0;
   localparam logic [7:0] PS2_EXT  = 8'hE0;
   localparam logic [7:0] PS2_BAT  = 8'hAA;
   localparam logic [7:0] PS2_ER0  = 8'h00;
   localparam logic [7:0] PS2_ER1  = 8'hFC;
   localparam logic [7:0] PS2_ER2  = 8'hFF;

   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_RIGHT = 8'h23;
   localparam logic [7:0] SC_LEFT  = 8'h1C;
   localparam logic [7:0] SC_ARR_L = 8'h6B;
   localparam logic [7:0] SC_ARR_R = 8'h74;

   localparam int KEY_SPACE = 0;
   localparam int KEY_RIGHT = 1;
   localparam int KEY_LEFT  = 2;
   localparam int NKEYS     = 3;

   typedef logic [NKEYS-1:0] keys_t;

   function automatic keys_t key_bit(input int idx);
      keys_t m;
      m = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

   // One-hot mask of the game key a plain scan code maps to, or zero.
   function automatic keys_t key_mask(input logic [7:0] code);
      keys_t m;
      m = '0;
      unique case (1'b1)
         (code == SC_SPACE): m = key_bit(KEY_SPACE);
         (code == SC_RIGHT): m = key_bit(KEY_RIGHT);
         (code == SC_LEFT):  m = key_bit(KEY_LEFT);
         default:            m = '0;
      endcase
      return m;
   endfunction

   function automatic keys_t arrow_mask(input logic [7:0] code);
      keys_t m;
      m = '0;
      unique case (1'b1)
         (code == SC_ARR_L): m = key_bit(KEY_LEFT);
         (code == SC_ARR_R): m = key_bit(KEY_RIGHT);
         default:            m = '0;
      endcase
      return m;
   endfunction

   function automatic logic is_err_byte(input logic [7:0] code);
      return (code == PS2_ER0) || (code == PS2_ER1) ||
             (code == PS2_ER2);
   endfunction

   function automatic logic is_prefix(input logic [7:0] code);
      return (code == PS2_BRK) || (code == PS2_EXT);
   endfunction

endpackage

// File: rtl/ps2_gap_timer.sv
// Gap counter between a prefix byte and its follow-up byte.
// Held at zero while not running; expire marks the last allowed cycle.
module ps2_gap_timer #(
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ?
                       $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;
   logic          at_last;

   assign at_last = (count == LAST);
   assign expire  = run && !clr && at_last;

   // Saturates at LAST; the FSM leaves the running states on expiry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr || !run) begin
         count <= '0;
      end else if (!at_last) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 make/break sequencer with per-key held flags and press/release pulses.
// Optional macro PS2_ARROW_KEYS_EN maps E0 6B / E0 74 onto left / right.
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       key_space,
   output logic       key_right,
   output logic       key_left,
   output logic [2:0] key_press,
   output logic [2:0] key_release,
   output logic       proto_err
);

   state_t state;
   state_t state_nx;
   keys_t  held;
   keys_t  held_nx;
   keys_t  mask;
   keys_t  amask;
   logic   err_nx;
   logic   quiet_nx;
   logic   run;
   logic   expire;

   assign run   = (state != ST_IDLE);
   assign mask  = key_mask(rx_data);
`ifdef PS2_ARROW_KEYS_EN
   assign amask = arrow_mask(rx_data);
`else
   assign amask = '0;
`endif

   ps2_gap_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_gap (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .clr    (rx_valid),
      .expire (expire)
   );

   always_comb begin
      state_nx = state;
      held_nx  = held;
      err_nx   = 1'b0;
      quiet_nx = 1'b0;
      if (rx_valid) begin
         unique case (state)
            ST_IDLE: begin
               unique case (1'b1)
                  (rx_data == PS2_BRK): state_nx = ST_BRK;
                  (rx_data == PS2_EXT): state_nx = ST_EXT;
                  (mask != '0): held_nx = held | mask;
                  (rx_data == PS2_BAT): begin
                     held_nx  = '0;
                     quiet_nx = 1'b1;
                  end
                  is_err_byte(rx_data): begin
                     held_nx = '0;
                     err_nx  = 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_BRK: begin
               state_nx = ST_IDLE;
               if (mask != '0) begin
                  held_nx = held & ~mask;
               end else if (is_prefix(rx_data)) begin
                  err_nx = 1'b1;
               end
            end
            ST_EXT: begin
               if (rx_data == PS2_BRK) begin
                  state_nx = ST_EXT_BRK;
               end else begin
                  state_nx = ST_IDLE;
                  held_nx  = held | amask;
               end
            end
            ST_EXT_BRK: begin
               state_nx = ST_IDLE;
               held_nx  = held & ~amask;
            end
            default: state_nx = ST_IDLE;
         endcase
      end else if (expire) begin
         state_nx = ST_IDLE;
         err_nx   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         held        <= '0;
         key_press   <= '0;
         key_release <= '0;
         proto_err   <= 1'b0;
      end else begin
         state       <= state_nx;
         held        <= held_nx;
         key_press   <= held_nx & ~held;
         key_release <= quiet_nx ? '0 : (held & ~held_nx);
         proto_err   <= err_nx;
      end
   end

   assign key_space = held[KEY_SPACE];
   assign key_right = held[KEY_RIGHT];
   assign key_left  = held[KEY_LEFT];

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: directed plan plus random byte stream.
// Reference model interprets the byte stream as pending-prefix sequences.
module tb_ps2_key_tracker;

   localparam int T = 16;

   typedef struct {
      logic [2:0] held;
      logic [2:0] press;
      logic [2:0] rel;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       key_space, key_right, key_left;
   logic [2:0] key_press, key_release;
   logic       proto_err;

   int tests = 0;
   int fails = 0;

   exp_t       q[$];
   logic [7:0] pfx[$];
   int         gap = 0;
   logic [2:0] m_held = '0;

   ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .key_space   (key_space),
      .key_right   (key_right),
      .key_left    (key_left),
      .key_press   (key_press),
      .key_release (key_release),
      .proto_err   (proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2:0] act,
                        input logic [2:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] plain_key(input logic [7:0] b);
      case (b)
         8'h29:   return 3'b001;
         8'h23:   return 3'b010;
         8'h1C:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] arrow_key(input logic [7:0] b);
`ifdef PS2_ARROW_KEYS_EN
      case (b)
         8'h6B:   return 3'b100;
         8'h74:   return 3'b010;
         default: return 3'b000;
      endcase
`else
      return 3'b000;
`endif
   endfunction

   // Expected outputs after one cycle carrying (v, b).
   task automatic model_step(input bit v, input logic [7:0] b);
      exp_t e;
      logic [2:0] nh;
      bit err, quiet;
      nh = m_held;
      err = 0;
      quiet = 0;
      if (!v) begin
         if (pfx.size() > 0) begin
            gap++;
            if (gap >= T) begin
               pfx.delete();
               gap = 0;
               err = 1;
            end
         end
      end else begin
         gap = 0;
         if (pfx.size() == 0) begin
            if (b == 8'hF0 || b == 8'hE0) pfx.push_back(b);
            else if (plain_key(b) != 0) nh = nh | plain_key(b);
            else if (b == 8'hAA) begin nh = 0; quiet = 1; end
            else if (b == 8'h00 || b == 8'hFC || b == 8'hFF) begin
               nh = 0;
               err = 1;
            end
         end else if (pfx.size() == 1 && pfx[0] == 8'hF0) begin
            pfx.delete();
            if (plain_key(b) != 0) nh = nh & ~plain_key(b);
            else if (b == 8'hE0 || b == 8'hF0) err = 1;
         end else if (pfx.size() == 1) begin
            if (b == 8'hF0) pfx.push_back(b);
            else begin
               pfx.delete();
               nh = nh | arrow_key(b);
            end
         end else begin
            pfx.delete();
            nh = nh & ~arrow_key(b);
         end
      end
      e.held  = nh;
      e.press = nh & ~m_held;
      e.rel   = quiet ? 3'b000 : (m_held & ~nh);
      e.err   = err;
      m_held  = nh;
      q.push_back(e);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      model_step(1, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         model_step(0, 8'h00);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_held"}, {key_left, key_right, key_space}, 3'b000);
      check({tag, "_press"}, key_press, 3'b000);
      check({tag, "_rel"}, key_release, 3'b000);
      check({tag, "_err"}, {2'b00, proto_err}, 3'b000);
   endtask

   // Monitor: one expected record per clock while out of reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst && q.size() > 0) begin
            e = q.pop_front();
            check("held", {key_left, key_right, key_space}, e.held);
            check("press", key_press, e.press);
            check("release", key_release, e.rel);
            check("proto_err", {2'b00, proto_err}, {2'b00, e.err});
         end
      end
   end

   function automatic logic [7:0] rand_byte();
      logic [7:0] pool[12];
      pool = '{8'h29, 8'h23, 8'h1C, 8'hF0, 8'hE0, 8'h6B,
               8'h74, 8'hAA, 8'h00, 8'hFC, 8'hFF, 8'h29};
      if ($urandom_range(0, 7) == 0) return 8'($urandom);
      return pool[$urandom_range(0, 11)];
   endfunction

   initial begin
      #3;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // make / break space
      send(8'h29); send(8'hF0); send(8'h29); idle(2);
      // typematic repeat and multiple keys
      send(8'h23); send(8'h23); send(8'h23); send(8'h1C);
      idle(1); send(8'hF0); send(8'h23); idle(2);
      // timeout abort, then 0x29 as a make
      send(8'hF0); idle(20); send(8'h29); idle(2);
      // byte coincides with expiry slot
      send(8'hF0); idle(T - 1); send(8'h29); idle(2);
      // error flush with space and left held
      send(8'h29); send(8'hFF); idle(2);
      // extended make / break
      send(8'hE0); send(8'h6B); idle(1);
      send(8'hE0); send(8'hF0); send(8'h6B); idle(1);
      send(8'hE0); send(8'h74); send(8'hE0); send(8'hF0);
      send(8'h74); idle(1);
      // BAT clears silently; break prefix errors
      send(8'h29); send(8'h1C); send(8'hAA); idle(1);
      send(8'hF0); send(8'hE0); idle(1);

      // reset mid-sequence after E0
      send(8'h29); send(8'hE0);
      @(negedge clk);
      rx_valid = 1'b0;
      #1 rst = 1'b0;
      #1 check_zero("midreset");
      m_held = '0;
      pfx.delete();
      gap = 0;
      @(negedge clk);
      rst = 1'b1;
      send(8'h29); idle(2);

      for (int i = 0; i < 1500; i++) begin
         send(rand_byte());
         case ($urandom_range(0, 19))
            0:       idle($urandom_range(T - 2, T + 2));
            1, 2, 3: idle($urandom_range(1, 3));
            default: ;
         endcase
      end
      idle(3);

      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      #2;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
